// File: rtl/demux4_router_if.sv
// Handshake bundle between the single-stream source and the four-port router.
// master = the producer/consumers side, slave = the router itself.
interface demux4_router_if #(
    parameter int SIZE = 32
);
    logic            InValid;
    logic            InReady;
    logic [1:0]      Sel;
    logic [SIZE-1:0] In;
    logic [3:0]      OutValid;
    logic [3:0]      OutReady;
    logic [SIZE-1:0] Out00;
    logic [SIZE-1:0] Out01;
    logic [SIZE-1:0] Out10;
    logic [SIZE-1:0] Out11;
    logic            Empty;

    modport master (
        output InValid, Sel, In, OutReady,
        input  InReady, OutValid, Out00, Out01, Out10, Out11, Empty
    );

    modport slave (
        input  InValid, Sel, In, OutReady,
        output InReady, OutValid, Out00, Out01, Out10, Out11, Empty
    );
endinterface

// File: rtl/demux4_router.sv
// Routes one SIZE-bit input stream to four output ports, each buffered by a
// 2-entry FIFO so a stalled consumer never blocks traffic to the other ports.
module demux4_router #(
    parameter int SIZE = 32
) (
    input  logic          Clk,
    input  logic          Reset_n,
    demux4_router_if.slave bus
);

    logic [1:0]      cnt_q  [4];
    logic [1:0]      cnt_d  [4];
    logic            wptr_q [4];
    logic            wptr_d [4];
    logic            rptr_q [4];
    logic            rptr_d [4];
    logic [SIZE-1:0] mem_q  [4][2];
    logic [SIZE-1:0] mem_d  [4][2];
    logic [SIZE-1:0] head   [4];
    logic [3:0]      port_push;
    logic [3:0]      port_pop;
    logic            in_ready;
    logic            push;

    // Ready looks only at the registered count of the addressed port.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        in_ready = (cnt_q[bus.Sel] != 2'd2);
        push     = bus.InValid && in_ready;
        for (int p = 0; p < 4; p++) begin
            port_push[p] = push && (bus.Sel == p[1:0]);
            port_pop[p]  = (cnt_q[p] != 2'd0) && bus.OutReady[p];
            cnt_d[p]     = cnt_q[p];
            wptr_d[p]    = wptr_q[p];
            rptr_d[p]    = rptr_q[p];
            mem_d[p][0]  = mem_q[p][0];
            mem_d[p][1]  = mem_q[p][1];
            if (port_push[p]) begin
                mem_d[p][wptr_q[p]] = bus.In;
                wptr_d[p]           = ~wptr_q[p];
            end
            if (port_pop[p]) begin
                rptr_d[p] = ~rptr_q[p];
            end
            case ({port_push[p], port_pop[p]})
                2'b10:   cnt_d[p] = cnt_q[p] + 2'd1;
                2'b01:   cnt_d[p] = cnt_q[p] - 2'd1;
                default: cnt_d[p] = cnt_q[p];
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int p = 0; p < 4; p++) begin
                cnt_q[p]  <= 2'd0;
                wptr_q[p] <= 1'b0;
                rptr_q[p] <= 1'b0;
            end
        end else begin
            // NOTE: non-blocking assignments keep all state updates simultaneous at the edge.
            for (int p = 0; p < 4; p++) begin
                cnt_q[p]  <= cnt_d[p];
                wptr_q[p] <= wptr_d[p];
                rptr_q[p] <= rptr_d[p];
            end
        end
    end

    // NOTE: storage is not reset; a zero count masks stale slots, so a reset drops every word.
    always_ff @(posedge Clk) begin
        for (int p = 0; p < 4; p++) begin
            mem_q[p][0] <= mem_d[p][0];
            mem_q[p][1] <= mem_d[p][1];
        end
    end

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            head[p] = (cnt_q[p] != 2'd0) ? mem_q[p][rptr_q[p]] : '0;
        end
    end

    assign bus.InReady     = in_ready;
    assign bus.OutValid[0] = (cnt_q[0] != 2'd0);
    assign bus.OutValid[1] = (cnt_q[1] != 2'd0);
    assign bus.OutValid[2] = (cnt_q[2] != 2'd0);
    assign bus.OutValid[3] = (cnt_q[3] != 2'd0);
    assign bus.Out00       = head[0];
    assign bus.Out01       = head[1];
    assign bus.Out10       = head[2];
    assign bus.Out11       = head[3];
    assign bus.Empty       = (cnt_q[0] == 2'd0) && (cnt_q[1] == 2'd0) &&
                             (cnt_q[2] == 2'd0) && (cnt_q[3] == 2'd0);

endmodule

// File: tb/tb_demux4_router.sv
// Bench for demux4_router: directed scenarios plus constrained-random traffic,
// all scored against per-port queues that model the 2-deep FIFOs.
module tb_demux4_router;
    localparam int SIZE = 32;

    logic Clk = 1'b0;
    logic Reset_n;
    int   checks = 0;
    int   errors = 0;
    logic pushed;

    logic [SIZE-1:0] model_q [4][$];

    always #5 Clk = ~Clk;

    demux4_router_if #(.SIZE(SIZE)) bus ();

    demux4_router #(.SIZE(SIZE)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [SIZE-1:0] got, input logic [SIZE-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [SIZE-1:0] port_out(input int p);
        case (p)
            0:       return bus.Out00;
            1:       return bus.Out01;
            2:       return bus.Out10;
            default: return bus.Out11;
        endcase
    endfunction

    task automatic compare_outputs();
        logic all_empty;
        all_empty = 1'b1;
        for (int p = 0; p < 4; p++) begin
            logic [SIZE-1:0] exp_data;
            exp_data = (model_q[p].size() != 0) ? model_q[p][0] : '0;
            if (model_q[p].size() != 0) all_empty = 1'b0;
            check($sformatf("out_valid%0d", p), SIZE'(bus.OutValid[p]), SIZE'(model_q[p].size() != 0));
            check($sformatf("out_data%0d", p), port_out(p), exp_data);
        end
        check("empty", SIZE'(bus.Empty), SIZE'(all_empty));
    endtask

    // Advance one clock: update the model from the inputs that were stable at the edge.
    task automatic cycle();
        logic [3:0] pops;
        @(posedge Clk);
        for (int p = 0; p < 4; p++) pops[p] = (model_q[p].size() != 0) && bus.OutReady[p];
        pushed = bus.InValid && (model_q[bus.Sel].size() < 2);
        for (int p = 0; p < 4; p++) if (pops[p]) void'(model_q[p].pop_front());
        if (pushed) model_q[bus.Sel].push_back(bus.In);
        #1;
        compare_outputs();
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [SIZE-1:0] data,
                         input logic [3:0] ordy);
        bus.InValid  = v;
        bus.Sel      = sel;
        bus.In       = data;
        bus.OutReady = ordy;
        #1;
        check("in_ready", SIZE'(bus.InReady), SIZE'(model_q[sel].size() != 2));
        cycle();
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) drive(1'b0, 2'd0, '0, 4'hF);
    endtask

    initial begin
        logic            v;
        logic [1:0]      sel;
        logic [SIZE-1:0] data;

        bus.InValid  = 1'b0;
        bus.Sel      = 2'd0;
        bus.In       = '0;
        bus.OutReady = 4'h0;
        pushed       = 1'b0;
        Reset_n      = 1'b0;
        #12;
        check("rst_valid", SIZE'(bus.OutValid), '0);
        check("rst_empty", SIZE'(bus.Empty), SIZE'(1));
        compare_outputs();
        Reset_n = 1'b1;

        // Routing: one word to each port, no consumer ready.
        for (int p = 0; p < 4; p++) drive(1'b1, p[1:0], SIZE'(32'hA0 + p), 4'h0);
        check("route_valid", SIZE'(bus.OutValid), SIZE'(4'hF));
        drain();

        // Full/backpressure on port 2.
        drive(1'b1, 2'd2, 32'h11, 4'h0);
        drive(1'b1, 2'd2, 32'h22, 4'h0);
        #1;
        check("full_ready", SIZE'(bus.InReady), '0);
        drive(1'b1, 2'd2, 32'h33, 4'h0);
        check("full_head", bus.Out10, 32'h11);
        drive(1'b1, 2'd2, 32'h33, 4'b0100);
        check("full_pop1", bus.Out10, 32'h22);
        drive(1'b1, 2'd2, 32'h33, 4'b0100);
        check("full_accept", bus.Out10, 32'h33);
        drain();

        // Simultaneous push and pop on port 0.
        drive(1'b1, 2'd0, 32'h5, 4'h0);
        drive(1'b1, 2'd0, 32'h6, 4'h1);
        check("pushpop_data", bus.Out00, 32'h6);
        drain();

        // Streaming 16 words to port 3.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'd3, SIZE'(32'hC00 + i), 4'h8);
            check("stream_data", bus.Out11, SIZE'(32'hC00 + i));
        end
        drain();

        // Isolation: port 1 full and stalled, port 0 still accepts.
        drive(1'b1, 2'd1, 32'h81, 4'h0);
        drive(1'b1, 2'd1, 32'h82, 4'h0);
        drive(1'b1, 2'd0, 32'h77, 4'h0);
        check("iso_p0", bus.Out00, 32'h77);
        check("iso_p1", bus.Out01, 32'h81);

        // Asynchronous reset mid-stream with two words on port 1.
        #2;
        Reset_n = 1'b0;
        #1;
        check("arst_valid", SIZE'(bus.OutValid), '0);
        check("arst_empty", SIZE'(bus.Empty), SIZE'(1));
        check("arst_out01", bus.Out01, '0);
        for (int p = 0; p < 4; p++) model_q[p].delete();
        #2;
        Reset_n = 1'b1;
        drive(1'b0, 2'd0, '0, 4'h0);

        // Random traffic; a refused word is held stable until accepted.
        v = 1'b0; sel = 2'd0; data = '0; pushed = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (!v || pushed) begin
                v    = ($urandom_range(0, 9) < 7);
                sel  = 2'($urandom_range(0, 3));
                data = SIZE'($urandom);
            end
            drive(v, sel, data, 4'($urandom_range(0, 15)));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
